semaphore_lock_ctrl: RTL



---
 rtl/semaphore_lock_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/semaphore_lock_ctrl.sv
// Hardware semaphore bank: a lock read is an atomic test-and-set, a lock write is an owner-only release,
// and each held lock can free itself after a programmable number of mclk cycles.
module semaphore_lock_ctrl #(
   parameter int NLOCK = 28,
   parameter int DW    = 32,
   parameter int AW    = 5,
   parameter int BW    = DW/8,
   parameter int MIDW  = 2,
   parameter int TOW   = 16
) (
   input  logic             mclk,
   input  logic             h_reset_n,
   input  logic             reg_cs,
   input  logic             reg_wr,
   input  logic [AW-1:0]    reg_addr,
   input  logic [DW-1:0]    reg_wdata,
   input  logic [BW-1:0]    reg_be,
   input  logic [MIDW-1:0]  reg_mid,
   output logic [DW-1:0]    reg_rdata,
   output logic             reg_ack,
   output logic [NLOCK-1:0] lock_status,
   output logic             irq
);

   localparam logic [AW-1:0] ADDR_STATUS   = AW'(28);
   localparam logic [AW-1:0] ADDR_TIMEOUT  = AW'(29);
   localparam logic [AW-1:0] ADDR_INT_STAT = AW'(30);
   localparam logic [AW-1:0] ADDR_INT_EN   = AW'(31);
   localparam logic [AW-1:0] NLOCK_A       = AW'(NLOCK);

   logic [NLOCK-1:0] held, held_nxt;
   logic [MIDW-1:0]  owner     [NLOCK];
   logic [MIDW-1:0]  owner_nxt [NLOCK];
   logic [TOW-1:0]   cnt       [NLOCK];
   logic [TOW-1:0]   cnt_nxt   [NLOCK];
   logic [TOW-1:0]   timeout, timeout_nxt;
   logic [2:0]       int_stat, int_stat_nxt;
   logic [2:0]       int_en, int_en_nxt;
   logic [2:0]       set_bits, clr_bits;
   logic [DW-1:0]    rdata_nxt;
   logic [MIDW-1:0]  dbg_owner;
   logic [NLOCK-1:0] hit, expire, is_owner, own_rel;
   logic             commit, is_lock, rd_grant, irq_nxt;

   assign commit      = reg_cs & ~reg_ack;
   assign is_lock     = (reg_addr < NLOCK_A);
   assign lock_status = held;

   // Descending scan so the lowest-numbered held lock wins
   always_comb begin
      dbg_owner = '0;
      for (int n = NLOCK-1; n >= 0; n--) begin
         if (held[n]) dbg_owner = owner[n];
      end
   end

   always_comb begin
      hit      = '0;
      expire   = '0;
      is_owner = '0;
      own_rel  = '0;
      for (int n = 0; n < NLOCK; n++) begin
         expire[n]   = held[n] && (cnt[n] == TOW'(1));
         is_owner[n] = held[n] && (owner[n] == reg_mid);
         hit[n]      = commit && (reg_addr == AW'(n));
         own_rel[n]  = hit[n] && reg_wr && reg_wdata[0] && is_owner[n];
      end
   end

   always_comb begin
      held_nxt  = held;
      owner_nxt = owner;
      cnt_nxt   = cnt;
      set_bits  = '0;
      rd_grant  = 1'b0;
      for (int n = 0; n < NLOCK; n++) begin
         if (held[n] && (cnt[n] != '0)) cnt_nxt[n] = cnt[n] - TOW'(1);
         if (expire[n]) begin
            held_nxt[n]  = 1'b0;
            owner_nxt[n] = '0;
         end
         // An expiring lock cannot be re-granted in the same cycle, even to its owner
         if (hit[n] && !reg_wr && !expire[n] && (!held[n] || is_owner[n])) begin
            held_nxt[n]  = 1'b1;
            owner_nxt[n] = reg_mid;
            cnt_nxt[n]   = timeout;
            rd_grant     = 1'b1;
         end
         if (hit[n] && reg_wr && reg_wdata[0]) begin
            if (is_owner[n]) begin
               held_nxt[n]  = 1'b0;
               owner_nxt[n] = '0;
               cnt_nxt[n]   = '0;
               set_bits[0]  = 1'b1;
            end else begin
               set_bits[2]  = 1'b1;
            end
         end
         if (expire[n] && !own_rel[n]) set_bits[1] = 1'b1;
      end
   end

   always_comb begin
      timeout_nxt = timeout;
      int_en_nxt  = int_en;
      clr_bits    = '0;
      if (commit && reg_wr) begin
         if (reg_addr == ADDR_TIMEOUT) begin
            for (int i = 0; i < TOW; i++) begin
               if (reg_be[i/8]) timeout_nxt[i] = reg_wdata[i];
            end
         end
         if ((reg_addr == ADDR_INT_STAT) && reg_be[0]) clr_bits   = reg_wdata[2:0];
         if ((reg_addr == ADDR_INT_EN) && reg_be[0])   int_en_nxt = reg_wdata[2:0];
      end
      int_stat_nxt = (int_stat & ~clr_bits) | set_bits;
      irq_nxt      = |(int_stat_nxt & int_en_nxt);
   end

   always_comb begin
      rdata_nxt = reg_rdata;
      if (commit && !reg_wr) begin
         rdata_nxt = '0;
         if (is_lock) begin
            rdata_nxt[0] = rd_grant;
         end else begin
            case (reg_addr)
               ADDR_STATUS:   rdata_nxt[NLOCK-1:0] = held;
               ADDR_TIMEOUT:  rdata_nxt[TOW-1:0]   = timeout;
               ADDR_INT_STAT: rdata_nxt[2:0]       = int_stat;
               ADDR_INT_EN: begin
                  rdata_nxt[2:0]      = int_en;
                  rdata_nxt[MIDW+7:8] = dbg_owner;
               end
               default: rdata_nxt = '0;
            endcase
         end
      end
   end

   always_ff @(posedge mclk or negedge h_reset_n) begin
      if (!h_reset_n) begin
         held      <= '0;
         timeout   <= '0;
         int_stat  <= '0;
         int_en    <= '0;
         reg_rdata <= '0;
         reg_ack   <= 1'b0;
         irq       <= 1'b0;
         for (int n = 0; n < NLOCK; n++) begin
            owner[n] <= '0;
            cnt[n]   <= '0;
         end
      end else begin
         held      <= held_nxt;
         owner     <= owner_nxt;
         cnt       <= cnt_nxt;
         timeout   <= timeout_nxt;
         int_stat  <= int_stat_nxt;
         int_en    <= int_en_nxt;
         reg_rdata <= rdata_nxt;
         reg_ack   <= commit;
         irq       <= irq_nxt;
      end
   end

endmodule
